// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program counter and registered decode context for the
// combinational control decoder, plus the Start/Ack/Done program handshake.
// Optional build macro: FETCH_CYCLE_CNT_EN adds a saturating 16-bit count of
// RUN cycles on CycleCnt; without it CycleCnt is tied to zero.
module fetch_sequencer #(
    parameter int PC_W       = 10,
    parameter int ROM_DEPTH  = 1024,
    parameter int START_ADDR = 0
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic [8:0]      Instruction,
    input  logic            BranchEn,
    input  logic [1:0]      NextState,
    input  logic [8:0]      PrevInstructionOut,
    input  logic [2:0]      CMPBitsOut,
    input  logic            CMPLoadEn,
    input  logic            Ack,
    output logic [PC_W-1:0] ProgCtr,
    output logic [1:0]      CurrState,
    output logic [8:0]      PrevInstruction,
    output logic [2:0]      CMPBits,
    output logic            Running,
    output logic            Done,
    output logic            Fault,
    output logic [15:0]     CycleCnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_HALT = 2'b10
    } seq_t;

    localparam logic [PC_W-1:0] START_PC  = PC_W'(START_ADDR);
    localparam logic [PC_W:0]   ROM_LIMIT = (PC_W+1)'(ROM_DEPTH);

    seq_t            state, state_n;
    logic [PC_W-1:0] pc_n;
    logic [1:0]      cs_n;
    logic [8:0]      prev_n;
    logic [2:0]      cmp_n;
    logic            done_n, fault_n;
    logic            jump;
    logic [PC_W:0]   cand;

    assign Running = (state == S_RUN);

    // Candidate next PC, one bit wider than the PC so overrun past ROM_DEPTH is visible
    always_comb begin
        jump = (CurrState == 2'b01) && PrevInstruction[8];
        cand = '0;
        if (jump) begin
            cand[8:0] = Instruction;
        end else if (BranchEn) begin
            cand = {1'b0, ProgCtr} + (PC_W+1)'(2);
        end else begin
            cand = {1'b0, ProgCtr} + (PC_W+1)'(1);
        end
    end

    // Sequencer next-state and next register values
    always_comb begin
        state_n = state;
        pc_n    = ProgCtr;
        cs_n    = CurrState;
        prev_n  = PrevInstruction;
        cmp_n   = CMPBits;
        done_n  = Done;
        fault_n = Fault;
        case (state)
            S_IDLE, S_HALT: begin
                if (Start) begin
                    state_n = S_RUN;
                    pc_n    = START_PC;
                    cs_n    = 2'b00;
                    prev_n  = '0;
                    cmp_n   = '0;
                    done_n  = 1'b0;
                    fault_n = 1'b0;
                end
            end
            S_RUN: begin
                if (CMPLoadEn) begin
                    cmp_n = CMPBitsOut;
                end
                if (Ack) begin
                    state_n = S_HALT;
                    done_n  = 1'b1;
                end else begin
                    prev_n = PrevInstructionOut;
                    if (CurrState == 2'b11) begin
                        cs_n = 2'b00;
                    end else if (cand >= ROM_LIMIT) begin
                        // PC and decode state are left exactly where the fault was seen
                        state_n = S_HALT;
                        fault_n = 1'b1;
                    end else begin
                        pc_n = cand[PC_W-1:0];
                        cs_n = jump ? 2'b00 : NextState;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State and context registers; reset wins over every other input
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state           <= S_IDLE;
            ProgCtr         <= START_PC;
            CurrState       <= 2'b00;
            PrevInstruction <= '0;
            CMPBits         <= '0;
            Done            <= 1'b0;
            Fault           <= 1'b0;
        end else begin
            state           <= state_n;
            ProgCtr         <= pc_n;
            CurrState       <= cs_n;
            PrevInstruction <= prev_n;
            CMPBits         <= cmp_n;
            Done            <= done_n;
            Fault           <= fault_n;
        end
    end

`ifdef FETCH_CYCLE_CNT_EN
    logic [15:0] cnt;
    logic        cnt_inc, cnt_clr;

    assign cnt_inc  = (state == S_RUN);
    assign cnt_clr  = Start && (state != S_RUN);
    assign CycleCnt = cnt;

    // Saturating RUN-cycle counter, cleared when a run is launched
    always_ff @(posedge Clk) begin
        if (Reset || cnt_clr) begin
            cnt <= '0;
        end else if (cnt_inc && (cnt != '1)) begin
            cnt <= cnt + 16'd1;
        end
    end
`else
    assign CycleCnt = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: the stimulus thread queues the
// hand-computed register values expected after each edge; a monitor on the
// falling edge pops and compares them. Instance "a" uses default parameters,
// instance "b" uses ROM_DEPTH = 16 for the out-of-range cases.
module tb_fetch_sequencer;

`ifdef FETCH_CYCLE_CNT_EN
    localparam int CNT_ON = 1;
`else
    localparam int CNT_ON = 0;
`endif

    localparam int F_PC = 0, F_CS = 1, F_PREV = 2, F_CMP = 3;
    localparam int F_RUN = 4, F_DONE = 5, F_FLT = 6, F_CNT = 7;

    logic       clk = 1'b0;
    logic       rst, start, br, cld, ack;
    logic [8:0] instr, pout;
    logic [1:0] ns;
    logic [2:0] cout;

    logic [9:0]  pc_a, pc_b;
    logic [1:0]  cs_a, cs_b;
    logic [8:0]  pr_a, pr_b;
    logic [2:0]  cm_a, cm_b;
    logic        run_a, run_b, done_a, done_b, flt_a, flt_b;
    logic [15:0] cnt_a, cnt_b;

    typedef struct {
        string       name;
        bit          inst_b;
        int          fld;
        logic [15:0] val;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    fetch_sequencer a (
        .Clk(clk), .Reset(rst), .Start(start), .Instruction(instr),
        .BranchEn(br), .NextState(ns), .PrevInstructionOut(pout),
        .CMPBitsOut(cout), .CMPLoadEn(cld), .Ack(ack),
        .ProgCtr(pc_a), .CurrState(cs_a), .PrevInstruction(pr_a),
        .CMPBits(cm_a), .Running(run_a), .Done(done_a), .Fault(flt_a),
        .CycleCnt(cnt_a)
    );

    fetch_sequencer #(.PC_W(10), .ROM_DEPTH(16), .START_ADDR(0)) b (
        .Clk(clk), .Reset(rst), .Start(start), .Instruction(instr),
        .BranchEn(br), .NextState(ns), .PrevInstructionOut(pout),
        .CMPBitsOut(cout), .CMPLoadEn(cld), .Ack(ack),
        .ProgCtr(pc_b), .CurrState(cs_b), .PrevInstruction(pr_b),
        .CMPBits(cm_b), .Running(run_b), .Done(done_b), .Fault(flt_b),
        .CycleCnt(cnt_b)
    );

    function automatic logic [15:0] observe(input bit inst_b, input int fld);
        logic [15:0] r;
        r = '0;
        case (fld)
            F_PC:   r = inst_b ? 16'(pc_b)   : 16'(pc_a);
            F_CS:   r = inst_b ? 16'(cs_b)   : 16'(cs_a);
            F_PREV: r = inst_b ? 16'(pr_b)   : 16'(pr_a);
            F_CMP:  r = inst_b ? 16'(cm_b)   : 16'(cm_a);
            F_RUN:  r = inst_b ? 16'(run_b)  : 16'(run_a);
            F_DONE: r = inst_b ? 16'(done_b) : 16'(done_a);
            F_FLT:  r = inst_b ? 16'(flt_b)  : 16'(flt_a);
            default: r = inst_b ? cnt_b : cnt_a;
        endcase
        return r;
    endfunction

    // Monitor: check every queued expectation against the settled outputs
    always @(negedge clk) begin
        exp_t        e;
        logic [15:0] act;
        while (q.size() > 0) begin
            e   = q.pop_front();
            act = observe(e.inst_b, e.fld);
            n_cmp++;
            if (act !== e.val) begin
                n_bad++;
                $display("FAIL %s (%s): got %0h expected %0h",
                         e.name, e.inst_b ? "b" : "a", act, e.val);
            end
        end
    end

    function automatic void ex(input string n, input int fld, input int v);
        q.push_back('{name: n, inst_b: 1'b0, fld: fld, val: 16'(v)});
    endfunction

    function automatic void exb(input string n, input int fld, input int v);
        q.push_back('{name: n, inst_b: 1'b1, fld: fld, val: 16'(v)});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [8:0] i, input logic bb, input logic [1:0] n,
                       input logic [8:0] p, input logic [2:0] c,
                       input logic l, input logic k);
        instr = i; br = bb; ns = n; pout = p; cout = c; cld = l; ack = k;
    endtask

    task automatic plain(input logic [8:0] p);
        drv(9'h000, 1'b0, 2'b00, p, 3'b000, 1'b0, 1'b0);
    endtask

    task automatic restart();
        rst = 1'b1; start = 1'b0;
        tick();
        rst = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic expect_reset(input string n);
        ex(n, F_PC, 0);   ex(n, F_CS, 0);   ex(n, F_PREV, 0); ex(n, F_CMP, 0);
        ex(n, F_RUN, 0);  ex(n, F_DONE, 0); ex(n, F_FLT, 0);  ex(n, F_CNT, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0;
        plain(9'h000);
        tick();
        expect_reset("reset");

        // Start, then five plain words
        rst = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        ex("start_pc", F_PC, 0); ex("start_run", F_RUN, 1); ex("start_cs", F_CS, 0);
        for (int unsigned k = 0; k < 5; k++) begin
            plain(9'h0A0 + 9'(k));
            tick();
            ex("seq_pc", F_PC, int'(k) + 1);
        end
        ex("seq_prev", F_PREV, 'h0A4); ex("seq_run", F_RUN, 1);
        drv(9'h000, 1'b0, 2'b00, 9'h0A5, 3'b010, 1'b1, 1'b0);
        tick();
        ex("cmp_pc", F_PC, 6); ex("cmp_load", F_CMP, 'b010);

        // Reset mid-run at PC 6 overrides Start/Ack/BranchEn
        rst = 1'b1; start = 1'b1;
        drv(9'h1FF, 1'b1, 2'b11, 9'h1FF, 3'b111, 1'b1, 1'b1);
        tick();
        rst = 1'b0; start = 1'b0;
        expect_reset("midrst");
        plain(9'h000);
        tick();
        ex("idle_run", F_RUN, 0); ex("idle_pc", F_PC, 0);

        // Branch word at 3, target 9'h014 at 4
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int unsigned k = 0; k < 3; k++) begin
            plain(9'h010 + 9'(k));
            tick();
        end
        ex("pre_br_pc", F_PC, 3);
        drv(9'h0C0, 1'b0, 2'b01, 9'h1C3, 3'b000, 1'b0, 1'b0);
        tick();
        ex("brw_pc", F_PC, 4); ex("brw_cs", F_CS, 1); ex("brw_prev", F_PREV, 'h1C3);
        drv(9'h014, 1'b0, 2'b10, 9'h014, 3'b000, 1'b0, 1'b0);
        tick();
        ex("jmp_pc", F_PC, 20); ex("jmp_cs", F_CS, 0); ex("jmp_prev", F_PREV, 'h014);
        exb("jmp_oor_pc", F_PC, 4); exb("jmp_oor_flt", F_FLT, 1); exb("jmp_oor_run", F_RUN, 0);

        // NOP state holds the PC, then a target state without bit 8 falls through
        drv(9'h000, 1'b0, 2'b11, 9'h020, 3'b000, 1'b0, 1'b0);
        tick();
        ex("to_nop_pc", F_PC, 21); ex("to_nop_cs", F_CS, 3);
        drv(9'h1FF, 1'b1, 2'b01, 9'h021, 3'b000, 1'b0, 1'b0);
        tick();
        ex("nop_pc", F_PC, 21); ex("nop_cs", F_CS, 0); ex("nop_prev", F_PREV, 'h021);
        drv(9'h000, 1'b0, 2'b01, 9'h055, 3'b000, 1'b0, 1'b0);
        tick();
        ex("tgt0_pc", F_PC, 22); ex("tgt0_cs", F_CS, 1);
        drv(9'h003, 1'b0, 2'b00, 9'h003, 3'b000, 1'b0, 1'b0);
        tick();
        ex("nojmp_pc", F_PC, 23); ex("nojmp_cs", F_CS, 0);

        // BranchEn at PC 7 skips to 9
        restart();
        for (int unsigned k = 0; k < 7; k++) begin
            plain(9'(k));
            tick();
        end
        ex("pre_skip_pc", F_PC, 7);
        drv(9'h000, 1'b1, 2'b10, 9'h007, 3'b000, 1'b0, 1'b0);
        tick();
        ex("skip_pc", F_PC, 9); ex("skip_cs", F_CS, 2); ex("skip_cnt", F_CNT, 8 * CNT_ON);

        // Ack at PC 12 with BranchEn: no skip, Done, HALT freezes, Start clears
        restart();
        for (int unsigned k = 0; k < 12; k++) begin
            if (k == 5) drv(9'h000, 1'b0, 2'b00, 9'h0AB, 3'b101, 1'b1, 1'b0);
            else        plain(9'h0AB);
            tick();
        end
        ex("pre_ack_pc", F_PC, 12); ex("pre_ack_cmp", F_CMP, 'b101);
        ex("pre_ack_cnt", F_CNT, 12 * CNT_ON);
        drv(9'h1EE, 1'b1, 2'b10, 9'h1EE, 3'b000, 1'b0, 1'b1);
        tick();
        ex("ack_pc", F_PC, 12); ex("ack_done", F_DONE, 1); ex("ack_run", F_RUN, 0);
        ex("ack_flt", F_FLT, 0); ex("ack_prev", F_PREV, 'h0AB); ex("ack_cs", F_CS, 0);
        ex("ack_cnt", F_CNT, 13 * CNT_ON);
        drv(9'h1FF, 1'b1, 2'b11, 9'h1FF, 3'b111, 1'b1, 1'b0);
        tick();
        ex("halt_pc", F_PC, 12); ex("halt_done", F_DONE, 1); ex("halt_cmp", F_CMP, 'b101);
        ex("halt_prev", F_PREV, 'h0AB); ex("halt_cnt", F_CNT, 13 * CNT_ON);
        start = 1'b1;
        plain(9'h000);
        tick();
        start = 1'b0;
        ex("rest_pc", F_PC, 0); ex("rest_run", F_RUN, 1); ex("rest_done", F_DONE, 0);
        ex("rest_cmp", F_CMP, 0); ex("rest_prev", F_PREV, 0); ex("rest_cs", F_CS, 0);
        ex("rest_cnt", F_CNT, 0);

        // ROM_DEPTH = 16: increment past 15 faults, Start recovers, Ack beats fault
        restart();
        for (int unsigned k = 0; k < 15; k++) begin
            plain(9'(k));
            tick();
        end
        exb("edge_pc", F_PC, 15); exb("edge_run", F_RUN, 1);
        plain(9'h00F);
        tick();
        exb("oor_pc", F_PC, 15); exb("oor_flt", F_FLT, 1); exb("oor_run", F_RUN, 0);
        exb("oor_done", F_DONE, 0); exb("oor_cnt", F_CNT, 16 * CNT_ON);
        start = 1'b1;
        tick();
        start = 1'b0;
        exb("rec_pc", F_PC, 0); exb("rec_flt", F_FLT, 0); exb("rec_run", F_RUN, 1);
        for (int unsigned k = 0; k < 15; k++) begin
            plain(9'(k));
            tick();
        end
        drv(9'h000, 1'b0, 2'b00, 9'h000, 3'b000, 1'b0, 1'b1);
        tick();
        exb("ackoor_done", F_DONE, 1); exb("ackoor_flt", F_FLT, 0); exb("ackoor_pc", F_PC, 15);

        plain(9'h000);
        tick();
        tick();
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Program-counter and control-state register stage sitting directly upstream of the combinational control decoder. Drives the instruction ROM address, holds the decoder's registered context (current decode state, previous instruction, compare flags), and applies the decoder's next-state and branch outputs at each clock edge. Also owns the start/done program handshake with the testbench/host.

## Interface
Parameters:
- PC_W, 10, program-counter width (must be ≥ 9)
- ROM_DEPTH, 1024, number of valid instruction words; legal PC range 0..ROM_DEPTH-1
- START_ADDR, 0, PC loaded on Start

Ports (one clock; reset is synchronous and active-high):
- Clk  in  1  clock, all state updates on rising edge
- Reset  in  1  synchronous active-high reset
- Start  in  1  one-cycle request to begin a program run
- Instruction  in  9  current ROM word at ProgCtr (combinational ROM)
- BranchEn  in  1  from decoder: skip following target word
- NextState  in  2  from decoder: next decode state
- PrevInstructionOut  in  9  from decoder: word to retain as PrevInstruction
- CMPBitsOut  in  3  from decoder: compare flags to retain
- CMPLoadEn  in  1  from decoder: load CMPBits
- Ack  in  1  from decoder: program complete
- ProgCtr  out  PC_W  instruction ROM address
- CurrState  out  2  decode state to decoder (00 regular, 01 target, 10 immediate, 11 NOP)
- PrevInstruction  out  9  registered previous instruction
- CMPBits  out  3  registered compare flags {zero, equal, gt}
- Running  out  1  high while in RUN
- Done  out  1  high in HALT after Ack
- Fault  out  1  high in HALT after out-of-range PC
- CycleCnt  out  16  RUN-cycle count (see Configuration)

## Operation
- Sequencer FSM: IDLE, RUN, HALT.
- IDLE: ProgCtr = START_ADDR, no register updates; Start → RUN (ProgCtr = START_ADDR, CurrState = 00).
- HALT: all outputs frozen; Start → RUN with ProgCtr = START_ADDR, CurrState = 00, CMPBits = 0, PrevInstruction = 0, Done = Fault = 0, CycleCnt = 0.
- RUN, per cycle, priority order:
  1. Ack = 1 → HALT, Done = 1, ProgCtr unchanged.
  2. CurrState = 11 → ProgCtr holds, CurrState ← 00.
  3. CurrState = 01 and PrevInstruction[8] = 1 → ProgCtr ← zero-extended Instruction, CurrState ← 00.
  4. BranchEn = 1 → ProgCtr ← ProgCtr + 2, CurrState ← NextState.
  5. Otherwise → ProgCtr ← ProgCtr + 1, CurrState ← NextState.
- In RUN, PrevInstruction ← PrevInstructionOut every cycle except the Ack cycle; CMPBits ← CMPBitsOut when CMPLoadEn = 1.
- Start while in RUN is ignored.
- Out of range: any computed next PC ≥ ROM_DEPTH (increment or jump target) → HALT, Fault = 1, ProgCtr unchanged; no wrap-around. Ack in the same cycle takes priority (Done = 1, Fault = 0).
- Arithmetic in PC_W+1 bits so overflow is detectable.

## Timing
- Reset values: ProgCtr = START_ADDR, CurrState = 00, PrevInstruction = 0, CMPBits = 0, Running = 0, Done = 0, Fault = 0, CycleCnt = 0, FSM = IDLE.
- Reset asserted mid-run overrides every other input on that edge.
- ROM and decoder are combinational: Instruction and decoder outputs are valid in the same cycle as ProgCtr; effects appear one edge later.
- Start → Running = 1 on the next edge; first instruction presented that cycle.
- Ack → Done = 1 and Running = 0 on the next edge.
- Taken branch costs 2 cycles (branch word + target word); untaken branch costs 1.

## Configuration
- FETCH_CYCLE_CNT_EN defined: CycleCnt increments once per RUN cycle (including the Ack cycle), saturates at 16'hFFFF, clears on Reset and Start, and freezes in HALT.
- Undefined: CycleCnt is tied to 0 and no counter is built.

## Test plan
- Reset, Start, then 5 plain ALU words (NextState = 00) → ProgCtr 0,1,2,3,4,5 on successive cycles; Running = 1.
- Branch at PC 3 with NextState = 01, then target word 9'h014 at PC 4 with PrevInstruction[8] = 1 → ProgCtr = 20, CurrState = 00.
- BranchEn = 1 at PC 7 → ProgCtr = 9; CurrState follows NextState.
- ROM_DEPTH = 16, PC at 15 with plain instruction → HALT, Fault = 1, ProgCtr stays 15; Start → ProgCtr = 0, Fault = 0.
- Ack at PC 12 together with BranchEn = 1 → Done = 1, ProgCtr = 12, no skip; with FETCH_CYCLE_CNT_EN, CycleCnt = 13.
- Reset asserted mid-run at PC 6 with CMPBits = 3'b010 → next edge: all outputs at reset values, FSM in IDLE.
